mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; width fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock shared with the control unit and datapath.
REQ-003 reset  input  1  asynchronous, active-high; one clock, no other clock domains.
REQ-004 start  input  1  one-cycle request from the control unit; sampled only in IDLE.
REQ-005 op  input  1  operation: 0 = MULT (signed), 1 = DIV (signed); sampled with start.
REQ-006 A  input  32  operand from register A (multiplicand / dividend); sampled with start.
REQ-007 B  input  32  operand from register B (multiplier / divisor); sampled with start.
REQ-008 busy  output  1  high while an operation is in progress, IDLE excluded.
REQ-009 done  output  1  one-cycle pulse when the result is committed (or div-by-zero is reported).
REQ-010 div_zero  output  1  one-cycle pulse coincident with done when DIV has B = 0.
REQ-011 HI  output  32  MULT: upper product word; DIV: remainder.
REQ-012 LO  output  32  MULT: lower product word; DIV: quotient.

Function
REQ-013 States: IDLE, MULT, DIV, FIX, DONE; state register updates on rising clk.
REQ-014 IDLE: on start=1, latch op/A/B, clear iteration counter, go to MULT (op=0) or DIV (op=1, B!=0), or DONE with div_zero (op=1, B=0).
REQ-015 start while busy=1 or while in DONE is ignored; no queueing.
REQ-016 MULT: radix-2 Booth, 65-bit accumulator {P_hi, P_lo, q-1}, one iteration per cycle, exactly 32 cycles, then DONE.
REQ-017 MULT result: full signed 64-bit product; HI = product[63:32], LO = product[31:0].
REQ-018 DIV: restoring division on magnitudes |A|, |B|, one iteration per cycle, exactly 32 cycles, then FIX.
REQ-019 FIX: quotient negated iff sign(A) != sign(B); remainder takes the sign of A; truncation toward zero.
REQ-020 DIV -2^31 / -1: LO = 0x80000000, HI = 0x00000000 (wrap, no flag).
REQ-021 DONE: HI/LO written on entry edge; done=1 for exactly this one cycle; next state IDLE.
REQ-022 Div-by-zero: HI/LO retain previous values; done and div_zero both pulse one cycle.
REQ-023 Latency, counted from the edge that samples start: MULT done high in cycle 33; DIV in cycle 34; div-by-zero in cycle 1.
REQ-024 HI/LO hold their last values between operations; they change only on DONE entry.
REQ-025 busy = 1 in MULT, DIV, FIX; busy = 0 in IDLE and DONE.
REQ-026 Iteration counter is 5 bits; the terminal count is 31; no wrap into a 33rd iteration.

Reset
REQ-027 reset=1 forces IDLE asynchronously, regardless of state.
REQ-028 Reset values: HI=0, LO=0, busy=0, done=0, div_zero=0, internal accumulators and counter = 0.
REQ-029 Reset mid-operation aborts it: no done pulse, and HI/LO read 0 after reset deasserts.
REQ-030 First start is accepted on the first rising edge with reset=0.

Structure
REQ-031 The shared package holds the state encoding (3-bit) and the op codes OP_MULT=0 and OP_DIV=1; the control unit imports the same op constants.
REQ-032 A single sub-module, booth_step (combinational add/sub-and-shift of the Booth accumulator), is instantiated once; the divider step stays inline.

Verification
REQ-033 MULT A=7, B=-3 -> done in cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high in cycles 1-32.
REQ-034 MULT A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0x00000000.
REQ-035 DIV A=-7, B=2 -> done in cycle 34; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
REQ-036 DIV A=5, B=0 (HI/LO preloaded with 0x11/0x22) -> done and div_zero in cycle 1; HI=0x11, LO=0x22.
REQ-037 DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0; a second start at cycle 10 is ignored.
REQ-038 MULT started, then reset asserted at cycle 15 -> no done pulse; HI=LO=0; a new MULT 3*4 gives LO=12 in cycle 33 after restart.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the 32-bit signed multiply/divide unit.
// The control unit imports the same op codes so both sides agree on encoding.
package mult_div_unit_pkg;

   localparam int XLEN  = 32;
   localparam int ACC_W = 2*XLEN + 1;   // {P_hi, P_lo, q-1}
   localparam int CNT_W = 5;

   // Last iteration index; 32 iterations run with indices 0..31.
   localparam logic [CNT_W-1:0] LAST_ITER = 5'd31;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MULT = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

   // Two's-complement negation, wrapping at 32 bits.
   function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v);
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   // Magnitude of a signed word as an unsigned word; -2^31 maps to 2^31.
   function automatic logic [XLEN-1:0] mag32(input logic [XLEN-1:0] v);
      return v[XLEN-1] ? neg32(v) : v;
   endfunction

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// One radix-2 Booth iteration: add/subtract the multiplicand into the upper
// half of the accumulator, then arithmetic-shift the whole accumulator right.
module booth_step
   import mult_div_unit_pkg::*;
(
   input  logic [ACC_W-1:0] acc_i,
   input  logic [XLEN-1:0]  mcand_i,
   output logic [ACC_W-1:0] acc_o
);

   // The partial sum is kept one bit wider so that adding or subtracting
   // -2^31 cannot lose the sign bit before the shift.
   logic [XLEN:0] hi_ext;
   logic [XLEN:0] m_ext;
   logic [XLEN:0] sum;

   // Booth recode on {P_lo[0], q-1}, then shift the sign-extended sum in.
   always_comb begin
      hi_ext = {acc_i[ACC_W-1], acc_i[ACC_W-1:XLEN+1]};
      m_ext  = {mcand_i[XLEN-1], mcand_i};
      case (acc_i[1:0])
         2'b01:   sum = hi_ext + m_ext;
         2'b10:   sum = hi_ext - m_ext;
         default: sum = hi_ext;
      endcase
      acc_o = {sum, acc_i[XLEN:1]};
   end

endmodule

// File: rtl/mult_div_unit.sv
// Signed 32x32 multiply (Booth, 32 cycles) and signed 32/32 divide
// (restoring on magnitudes, 32 cycles plus a sign-fix cycle).
// HI/LO are only written when DONE is entered and otherwise hold.
module mult_div_unit
   import mult_div_unit_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            op,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            busy,
   output logic            done,
   output logic            div_zero,
   output logic [XLEN-1:0] HI,
   output logic [XLEN-1:0] LO
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;

   // Multiplier datapath
   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] acc_d;
   logic [XLEN-1:0]  mcand_q;

   // Divider datapath (unsigned magnitudes plus sign-fix flags)
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  quot_q;
   logic [XLEN-1:0]  dvsr_q;
   logic             neg_quot_q;
   logic             neg_rem_q;
   logic [XLEN-1:0]  rem_d;
   logic [XLEN-1:0]  quot_d;
   logic [XLEN:0]    rem_sh;
   logic [XLEN:0]    trial;
   logic [XLEN-1:0]  rem_fix;
   logic [XLEN-1:0]  quot_fix;

   // Registered outputs
   logic             busy_q;
   logic             done_q;
   logic             dz_q;
   logic [XLEN-1:0]  hi_q;
   logic [XLEN-1:0]  lo_q;

   booth_step u_booth (
      .acc_i   (acc_q),
      .mcand_i (mcand_q),
      .acc_o   (acc_d)
   );

   // Restoring divide step: shift the next dividend bit into the remainder and
   // keep the trial difference only when it does not borrow. The quotient
   // register doubles as the dividend shift register.
   always_comb begin
      rem_sh = {rem_q, quot_q[XLEN-1]};
      trial  = rem_sh - {1'b0, dvsr_q};
      if (trial[XLEN]) begin
         rem_d  = rem_sh[XLEN-1:0];
         quot_d = {quot_q[XLEN-2:0], 1'b0};
      end else begin
         rem_d  = trial[XLEN-1:0];
         quot_d = {quot_q[XLEN-2:0], 1'b1};
      end
   end

   // Sign fix for truncating division: quotient negative when operand signs
   // differ, remainder follows the dividend. -2^31 / -1 wraps to 0x80000000.
   always_comb begin
      quot_fix = neg_quot_q ? neg32(quot_q) : quot_q;
      rem_fix  = neg_rem_q  ? neg32(rem_q)  : rem_q;
   end

   // Control FSM with all datapath registers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         dvsr_q     <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  cnt_q      <= '0;
                  mcand_q    <= A;
                  acc_q      <= {{XLEN{1'b0}}, B, 1'b0};
                  rem_q      <= '0;
                  quot_q     <= mag32(A);
                  dvsr_q     <= mag32(B);
                  neg_quot_q <= A[XLEN-1] ^ B[XLEN-1];
                  neg_rem_q  <= A[XLEN-1];
                  if (op == OP_MULT) begin
                     state_q <= ST_MULT;
                     busy_q  <= 1'b1;
                  end else if (B == '0) begin
                     // Report immediately; HI/LO keep their old values.
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     dz_q    <= 1'b1;
                  end else begin
                     state_q <= ST_DIV;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_MULT: begin
               acc_q <= acc_d;
               if (cnt_q == LAST_ITER) begin
                  // Commit the final step's result directly on DONE entry.
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  hi_q    <= acc_d[ACC_W-1:XLEN+1];
                  lo_q    <= acc_d[XLEN:1];
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            ST_DIV: begin
               rem_q  <= rem_d;
               quot_q <= quot_d;
               if (cnt_q == LAST_ITER) begin
                  state_q <= ST_FIX;
               end else begin
                  cnt_q <= cnt_q + 5'd1;
               end
            end
            ST_FIX: begin
               state_q <= ST_DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               hi_q    <= rem_fix;
               lo_q    <= quot_fix;
            end
            ST_DONE: begin
               // A start seen here is dropped, not queued.
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;
   assign HI       = hi_q;
   assign LO       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases from the requirements plus random
// operations checked against a longint arithmetic reference model.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] HI;
   logic [31:0] LO;

   int          errs   = 0;
   int          checks = 0;
   logic [31:0] mdl_hi = '0;
   logic [31:0] mdl_lo = '0;

   always #5 clk = ~clk;

   mult_div_unit u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .HI       (HI),
      .LO       (LO)
   );

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // Reference model: plain signed arithmetic on 64-bit integers.
   task automatic model(input logic o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz, output int lat);
      longint sa, sb, p, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      if (o == OP_MULT) begin
         p   = sa * sb;
         hi  = p[63:32];
         lo  = p[31:0];
         lat = 33;
      end else if (b == 32'd0) begin
         hi  = mdl_hi;
         lo  = mdl_lo;
         dz  = 1'b1;
         lat = 1;
      end else begin
         q   = sa / sb;
         r   = sa % sb;
         hi  = r[31:0];
         lo  = q[31:0];
         lat = 34;
      end
   endtask

   // Issue one operation and watch it to completion. lat is the cycle (from
   // the sampling edge) in which done is seen; busy_ok tracks the busy shape.
   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] hi, output logic [31:0] lo,
                         output logic dz, output logic busy_ok);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_ok = 1'b1;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      if (busy !== 1'b0) busy_ok = 1'b0;
      hi = HI; lo = LO; dz = div_zero;
   endtask

   task automatic test_reset;
      int lat;
      reset = 1'b1; start = 1'b1; op = OP_MULT; A = 32'd2; B = 32'd5;
      repeat (2) @(negedge clk);
      checks++;
      if ({HI, LO} !== 64'd0) begin
         errs++; $display("FAIL reset_hilo: got %h_%h want 0_0", HI, LO);
      end
      checks++;
      if ({busy, done, div_zero} !== 3'b000) begin
         errs++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_zero});
      end
      // start is already high, so the first edge with reset low must take it
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk); lat++;
      end
      checks++;
      if (lat !== 33 || LO !== 32'd10 || HI !== 32'd0) begin
         errs++; $display("FAIL first_start: lat=%0d HI=%h LO=%h want 33 0 a", lat, HI, LO);
      end
      mdl_hi = 32'd0; mdl_lo = 32'd10;
   endtask

   task automatic test_mult_directed;
      logic [31:0] ta [2], tb [2], ehi [2], elo [2];
      logic [31:0] hi, lo;
      logic dz, bok;
      int lat;
      ta[0] = 32'd7;        tb[0] = 32'hFFFF_FFFD; ehi[0] = 32'hFFFF_FFFF; elo[0] = 32'hFFFF_FFEB;
      ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000; ehi[1] = 32'h4000_0000; elo[1] = 32'h0;
      for (int i = 0; i < 2; i++) begin
         run_op(OP_MULT, ta[i], tb[i], lat, hi, lo, dz, bok);
         checks++;
         if (lat !== 33 || bok !== 1'b1 || dz !== 1'b0) begin
            errs++; $display("FAIL mult_timing[%0d]: lat=%0d busy_ok=%b dz=%b want 33 1 0", i, lat, bok, dz);
         end
         checks++;
         if (hi !== ehi[i] || lo !== elo[i]) begin
            errs++; $display("FAIL mult_result[%0d]: got %h_%h want %h_%h", i, hi, lo, ehi[i], elo[i]);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errs++; $display("FAIL mult_done_pulse[%0d]: done=%b want 0", i, done);
         end
         mdl_hi = ehi[i]; mdl_lo = elo[i];
      end
   endtask

   task automatic test_div_directed;
      logic [31:0] hi, lo;
      logic dz, bok;
      int lat;
      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, hi, lo, dz, bok);
      checks++;
      if (lat !== 34 || bok !== 1'b1 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         errs++; $display("FAIL div_neg7_2: lat=%0d busy_ok=%b got %h_%h want 34 1 ffffffff_fffffffd", lat, bok, hi, lo);
      end
      // preload HI=0x11, LO=0x22 via 0x2211 / 0x100
      run_op(OP_DIV, 32'h2211, 32'h100, lat, hi, lo, dz, bok);
      checks++;
      if (hi !== 32'h11 || lo !== 32'h22) begin
         errs++; $display("FAIL div_preload: got %h_%h want 11_22", hi, lo);
      end
      run_op(OP_DIV, 32'd5, 32'd0, lat, hi, lo, dz, bok);
      checks++;
      if (lat !== 1 || dz !== 1'b1 || bok !== 1'b1) begin
         errs++; $display("FAIL div_zero_flag: lat=%0d dz=%b busy_ok=%b want 1 1 1", lat, dz, bok);
      end
      checks++;
      if (hi !== 32'h11 || lo !== 32'h22) begin
         errs++; $display("FAIL div_zero_hold: got %h_%h want 11_22", hi, lo);
      end
      @(negedge clk);
      checks++;
      if ({done, div_zero} !== 2'b00) begin
         errs++; $display("FAIL div_zero_pulse: done/dz=%b want 00", {done, div_zero});
      end
      mdl_hi = 32'h11; mdl_lo = 32'h22;
   endtask

   task automatic test_div_overflow_ignore;
      int lat;
      int extra;
      @(negedge clk);
      start = 1'b1; op = OP_DIV; A = 32'h8000_0000; B = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         // a second request while busy must be dropped
         if (lat == 10) begin
            start = 1'b1; op = OP_MULT; A = 32'd3; B = 32'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk); lat++;
      end
      checks++;
      if (lat !== 34 || HI !== 32'h0 || LO !== 32'h8000_0000) begin
         errs++; $display("FAIL div_overflow: lat=%0d got %h_%h want 34 0_80000000", lat, HI, LO);
      end
      // request during DONE is dropped too
      start = 1'b1; op = OP_MULT; A = 32'd3; B = 32'd3;
      @(negedge clk);
      start = 1'b0;
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1 || busy === 1'b1) extra++;
         @(negedge clk);
      end
      checks++;
      if (extra !== 0 || LO !== 32'h8000_0000) begin
         errs++; $display("FAIL ignored_start: active_cycles=%0d LO=%h want 0 80000000", extra, LO);
      end
      mdl_hi = 32'h0; mdl_lo = 32'h8000_0000;
   endtask

   task automatic test_reset_midop;
      logic [31:0] hi, lo;
      logic dz, bok;
      int lat;
      int seen;
      @(negedge clk);
      start = 1'b1; op = OP_MULT; A = 32'h0001_2345; B = 32'h0000_0777;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, HI, LO} !== 66'd0) begin
         errs++; $display("FAIL reset_async: busy=%b done=%b HI=%h LO=%h want all 0", busy, done, HI, LO);
      end
      @(negedge clk);
      reset = 1'b0;
      mdl_hi = '0; mdl_lo = '0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done === 1'b1) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen !== 0 || HI !== 32'd0 || LO !== 32'd0) begin
         errs++; $display("FAIL reset_abort: done_seen=%0d HI=%h LO=%h want 0 0 0", seen, HI, LO);
      end
      run_op(OP_MULT, 32'd3, 32'd4, lat, hi, lo, dz, bok);
      checks++;
      if (lat !== 33 || hi !== 32'd0 || lo !== 32'd12) begin
         errs++; $display("FAIL restart_mult: lat=%0d got %h_%h want 33 0_c", lat, hi, lo);
      end
      mdl_hi = 32'd0; mdl_lo = 32'd12;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random;
      logic [31:0] a, b, ehi, elo, hi, lo;
      logic o, edz, dz, bok;
      int elat, lat;
      for (int n = 0; n < 40; n++) begin
         o = 1'($urandom_range(0, 1));
         a = pick_operand();
         b = pick_operand();
         model(o, a, b, ehi, elo, edz, elat);
         run_op(o, a, b, lat, hi, lo, dz, bok);
         checks++;
         if (lat !== elat) begin
            errs++; $display("FAIL rand_latency[%0d]: op=%b a=%h b=%h got %0d want %0d", n, o, a, b, lat, elat);
         end
         checks++;
         if (hi !== ehi || lo !== elo) begin
            errs++; $display("FAIL rand_result[%0d]: op=%b a=%h b=%h got %h_%h want %h_%h", n, o, a, b, hi, lo, ehi, elo);
         end
         checks++;
         if (dz !== edz || bok !== 1'b1) begin
            errs++; $display("FAIL rand_flags[%0d]: op=%b a=%h b=%h dz=%b busy_ok=%b want %b 1", n, o, a, b, dz, bok, edz);
         end
         mdl_hi = ehi; mdl_lo = elo;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;
      test_reset();
      test_mult_directed();
      test_div_directed();
      test_div_overflow_ignore();
      test_reset_midop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
